// File: rtl/esp32_oled_spi_rx_pkg.sv
// Shared types and constants for the ESP32 OLED SPI receive tap.
// The FIFO entry is {first, dc, data}, with first in the MSB.
package esp32_oled_spi_rx_pkg;

  localparam int SPI_BITS = 8;
  localparam int ENTRY_W  = SPI_BITS + 2;
  localparam int CNT_W    = $clog2(SPI_BITS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic                first;
    logic                dc;
    logic [SPI_BITS-1:0] data;
  } rx_entry_t;

  function automatic logic [SPI_BITS-1:0] shift_in(input logic [SPI_BITS-1:0] v, input logic b);
    return {v[SPI_BITS-2:0], b};
  endfunction

endpackage

// File: rtl/esp32_oled_spi_rx_if.sv
// Byte stream from the SPI tap to its consumer.
// valid/ready: the head entry transfers on any rising clock edge where rx_valid & rx_ready are both 1.
// While rx_valid is 1 and rx_ready is 0, rx_data/rx_dc/rx_first stay stable and rx_valid stays high.
// rx_valid never depends combinationally on rx_ready.
interface esp32_oled_spi_rx_if;

  logic [esp32_oled_spi_rx_pkg::SPI_BITS-1:0] rx_data;
  logic                                       rx_dc;
  logic                                       rx_first;
  logic                                       rx_valid;
  logic                                       rx_ready;

  modport master (
    output rx_data,
    output rx_dc,
    output rx_first,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_dc,
    input  rx_first,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/esp32_oled_spi_rx_sync_fifo.sv
// Small synchronous FIFO with a registered head entry and registered valid.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module esp32_oled_spi_rx_sync_fifo #(
  parameter int WIDTH     = 10,
  parameter int ADDR_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] PTR_ONE = (ADDR_BITS + 1)'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic [ADDR_BITS:0] wr_next;
  logic [ADDR_BITS:0] rd_next;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic               empty_next;
  logic               fwd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                   (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    if (do_push) wr_next = wr_ptr + PTR_ONE;
    if (do_pop)  rd_next = rd_ptr + PTR_ONE;
  end

  assign empty_next = (wr_next == rd_next);
  // The new head may be the slot being written this very cycle.
  assign fwd = do_push && (rd_next[ADDR_BITS-1:0] == wr_ptr[ADDR_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_BITS-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_data  <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      head_valid <= ~empty_next;
      if (!empty_next) head_data <= fwd ? push_data : mem[rd_next[ADDR_BITS-1:0]];
    end
  end

endmodule

// File: rtl/esp32_oled_spi_rx.sv
// Oversampling SPI slave tap: assembles tagged bytes from the ESP32 OLED stream into a FIFO
// and returns one byte per frame on MISO.
module esp32_oled_spi_rx
  import esp32_oled_spi_rx_pkg::*;
#(
  parameter int C_fifo_addr_bits = 2,
  parameter int C_sync_stages    = 2
) (
  input  logic                clk_25mhz,
  input  logic                rstn,
  input  logic                spi_csn,
  input  logic                spi_sclk,
  input  logic                spi_mosi,
  input  logic                spi_dc,
  input  logic [SPI_BITS-1:0] miso_data,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic                overflow,
  output logic                frame_err,
  input  logic                clr_err,
  output state_e              dbg_state,
  esp32_oled_spi_rx_if.master rx
);

  localparam int S = C_sync_stages;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPI_BITS - 1);

  logic [S-1:0] csn_sync;
  logic [S-1:0] sclk_sync;
  logic [S-1:0] mosi_sync;
  logic [S-1:0] dc_sync;
  logic         csn_d;
  logic         sclk_d;
  logic         csn_s;
  logic         sclk_s;
  logic         mosi_s;
  logic         dc_s;
  logic         sclk_rise;
  logic         sclk_fall;
  logic         csn_fall;
  logic         csn_rise;

  state_e              state_q;
  logic [CNT_W-1:0]    bitcnt;
  logic [CNT_W-1:0]    bitcnt_after;
  logic [SPI_BITS-1:0] shreg;
  logic [SPI_BITS-1:0] miso_shreg;
  logic                first_flag;
  logic                push_q;
  rx_entry_t           push_entry;
  logic                byte_done;
  logic                frame_err_set;
  logic                overflow_set;
  logic                pop;
  logic                fifo_full;
  logic [ENTRY_W-1:0]  head_vec;
  rx_entry_t           head;

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      csn_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      csn_d     <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[S-2:0], spi_csn};
      sclk_sync <= {sclk_sync[S-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[S-2:0], spi_mosi};
      dc_sync   <= {dc_sync[S-2:0], spi_dc};
      csn_d     <= csn_s;
      sclk_d    <= sclk_s;
    end
  end

  assign csn_s  = csn_sync[S-1];
  assign sclk_s = sclk_sync[S-1];
  assign mosi_s = mosi_sync[S-1];
  assign dc_s   = dc_sync[S-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign csn_rise  = csn_s & ~csn_d;

  assign byte_done     = (state_q == ST_ACTIVE) && sclk_rise && (bitcnt == CNT_LAST);
  assign bitcnt_after  = bitcnt + CNT_W'(sclk_rise);
  // A last bit arriving with csn_rise completes the byte, so it is not a framing error.
  assign frame_err_set = (state_q == ST_ACTIVE) && csn_rise && (bitcnt_after != '0);
  assign pop           = rx.rx_ready & rx.rx_valid;
  assign overflow_set  = push_q & fifo_full & ~pop;

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      miso_shreg <= '0;
      first_flag <= 1'b0;
      push_q     <= 1'b0;
      push_entry <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      overflow  <= overflow_set | (overflow & ~clr_err);
      frame_err <= frame_err_set | (frame_err & ~clr_err);
      case (state_q)
        ST_IDLE: begin
          if (csn_fall) begin
            state_q    <= ST_ACTIVE;
            bitcnt     <= '0;
            first_flag <= 1'b1;
            miso_shreg <= miso_data;
          end
        end
        ST_ACTIVE: begin
          if (sclk_rise) begin
            shreg  <= shift_in(shreg, mosi_s);
            bitcnt <= bitcnt_after;
          end
          if (byte_done) begin
            push_q     <= 1'b1;
            push_entry <= '{first: first_flag, dc: dc_s, data: shift_in(shreg, mosi_s)};
            first_flag <= 1'b0;
          end
          if (sclk_fall) miso_shreg <= shift_in(miso_shreg, 1'b0);
          if (csn_rise)  state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_shreg[SPI_BITS-1];
  assign spi_miso_oe = ~csn_s;
  assign dbg_state   = state_q;

  esp32_oled_spi_rx_sync_fifo #(
    .WIDTH     (ENTRY_W),
    .ADDR_BITS (C_fifo_addr_bits)
  ) u_fifo (
    .clk        (clk_25mhz),
    .rst_n      (rstn),
    .push       (push_q),
    .push_data  (push_entry),
    .full       (fifo_full),
    .pop        (pop),
    .head_data  (head_vec),
    .head_valid (rx.rx_valid)
  );

  assign head        = rx_entry_t'(head_vec);
  assign rx.rx_data  = head.data;
  assign rx.rx_dc    = head.dc;
  assign rx.rx_first = head.first;

endmodule

// File: tb/tb_esp32_oled_spi_rx.sv
// Bench for esp32_oled_spi_rx: directed SPI frames with random payloads, checked against
// a queue-based model of a 4-deep byte FIFO plus MISO and error-flag expectations.
module tb_esp32_oled_spi_rx;
  import esp32_oled_spi_rx_pkg::*;

  localparam int S     = 2;
  localparam int AB    = 2;
  localparam int DEPTH = 1 << AB;
  localparam int T     = 40;

  // clock / reset
  logic       clk       = 1'b0;
  logic       rstn      = 1'b0;
  logic       spi_csn   = 1'b1;
  logic       spi_sclk  = 1'b0;
  logic       spi_mosi  = 1'b0;
  logic       spi_dc    = 1'b0;
  logic       clr_err   = 1'b0;
  logic [7:0] miso_data = 8'h00;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       overflow;
  logic       frame_err;
  state_e     dbg_state;

  esp32_oled_spi_rx_if rx_bus();

  always #(T/2) clk = ~clk;

  esp32_oled_spi_rx #(
    .C_fifo_addr_bits (AB),
    .C_sync_stages    (S)
  ) dut (
    .clk_25mhz   (clk),
    .rstn        (rstn),
    .spi_csn     (spi_csn),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_dc      (spi_dc),
    .miso_data   (miso_data),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .clr_err     (clr_err),
    .dbg_state   (dbg_state),
    .rx          (rx_bus)
  );

  // scoreboard / model state
  int         total = 0;
  int         bad   = 0;
  logic [9:0] exp_q[$];
  logic       miso_seen[$];
  bit         exp_ovf     = 1'b0;
  bit         exp_ferr    = 1'b0;
  bit         frame_first = 1'b0;
  int         lat         = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(rx_bus.rx_valid), 32'd0);
    chk({tag, "_data"},  32'(rx_bus.rx_data),  32'd0);
    chk({tag, "_dc"},    32'(rx_bus.rx_dc),    32'd0);
    chk({tag, "_first"}, 32'(rx_bus.rx_first), 32'd0);
    chk({tag, "_miso"},  32'(spi_miso),        32'd0);
    chk({tag, "_oe"},    32'(spi_miso_oe),     32'd0);
    chk({tag, "_ovf"},   32'(overflow),        32'd0);
    chk({tag, "_ferr"},  32'(frame_err),       32'd0);
    chk({tag, "_state"}, 32'(dbg_state),       32'(ST_IDLE));
  endtask

  // driver tasks (all inputs change just after a falling clock edge)
  task automatic frame_begin(input int half);
    spi_csn     = 1'b0;
    frame_first = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic frame_end(input int half, input bit partial);
    repeat (half) @(negedge clk);
    spi_csn = 1'b1;
    if (partial) exp_ferr = 1'b1;
    repeat (S + 6) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc, input int half, input int nbits,
                          input bit measure, input bit pop_here, input bit csn_at_last);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      spi_dc   = dc;
      repeat (half) @(negedge clk);
      miso_seen.push_back(spi_miso);
      spi_sclk = 1'b1;
      if (csn_at_last && i == nbits - 1) spi_csn = 1'b1;
      for (int c = 1; c <= half; c++) begin
        @(posedge clk);
        #1;
        if (measure && i == nbits - 1 && lat == 0 && rx_bus.rx_valid) lat = c;
        @(negedge clk);
        if (pop_here && i == nbits - 1) begin
          if (c == S + 1) begin
            chk("full_pop_head", 32'({rx_bus.rx_first, rx_bus.rx_dc, rx_bus.rx_data}),
                32'(exp_q.pop_front()));
            rx_bus.rx_ready = 1'b1;
          end else if (c == S + 2) begin
            rx_bus.rx_ready = 1'b0;
          end
        end
      end
      spi_sclk = 1'b0;
    end
    if (nbits == 8) begin
      model_push({frame_first, dc, b});
      frame_first = 1'b0;
    end
  endtask

  task automatic drain(input int n, input string tag);
    logic [9:0] e;
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!rx_bus.rx_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk({tag, "_valid"}, 32'(rx_bus.rx_valid), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
      chk({tag, "_entry"}, 32'({rx_bus.rx_first, rx_bus.rx_dc, rx_bus.rx_data}), 32'(e));
      rx_bus.rx_ready = 1'b1;
      @(negedge clk);
      rx_bus.rx_ready = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_left"}, 32'(rx_bus.rx_valid), 32'(exp_q.size() != 0));
  endtask

  task automatic check_miso(input logic [7:0] md, input string tag);
    logic eb;
    for (int k = 0; k < miso_seen.size(); k++) begin
      if (k < 8) eb = md[7-k];
      else eb = 1'b0;
      chk({tag, "_miso"}, 32'(miso_seen[k]), 32'(eb));
    end
    miso_seen.delete();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #(T * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       d;
    int         n;
    int         h;
    rx_bus.rx_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // single byte 0xA5 dc=1 at ~1 MHz, with latency measurement
    lat = 0;
    frame_begin(12);
    spi_byte(8'hA5, 1'b1, 12, 8, 1'b1, 1'b0, 1'b0);
    frame_end(12, 1'b0);
    chk("t1_latency", 32'(lat), 32'(S + 2));
    drain(1, "t1");
    chk("t1_ferr", 32'(frame_err), 32'(exp_ferr));
    chk("t1_ovf", 32'(overflow), 32'(exp_ovf));
    miso_seen.delete();

    // two-byte frame, MISO returns 0x3C then zeros
    miso_data = 8'h3C;
    frame_begin(4);
    spi_byte(8'h12, 1'b0, 4, 8, 1'b0, 1'b0, 1'b0);
    spi_byte(8'h34, 1'b1, 4, 8, 1'b0, 1'b0, 1'b0);
    frame_end(4, 1'b0);
    check_miso(8'h3C, "t2");
    drain(2, "t2");

    // six bytes with consumer stalled: first four kept, overflow set
    frame_begin(4);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      spi_byte(b, d, 4, 8, 1'b0, 1'b0, 1'b0);
    end
    frame_end(4, 1'b0);
    chk("t3_ovf_set", 32'(overflow), 32'(exp_ovf));
    drain(4, "t3");
    pulse_clr();
    chk("t3_ovf_clr", 32'(overflow), 32'(exp_ovf));
    miso_seen.delete();

    // partial byte then a clean frame
    frame_begin(4);
    spi_byte(8'($urandom_range(0, 255)), 1'b0, 4, 5, 1'b0, 1'b0, 1'b0);
    frame_end(4, 1'b1);
    chk("t4_ferr_set", 32'(frame_err), 32'(exp_ferr));
    chk("t4_no_push", 32'(rx_bus.rx_valid), 32'd0);
    frame_begin(4);
    spi_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4, 8, 1'b0, 1'b0, 1'b0);
    frame_end(4, 1'b0);
    drain(1, "t4");
    pulse_clr();
    chk("t4_ferr_clr", 32'(frame_err), 32'(exp_ferr));

    // full FIFO, pop coincides with the fifth push
    frame_begin(8);
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      spi_byte(b, d, 8, 8, 1'b0, (k == 4), 1'b0);
    end
    frame_end(8, 1'b0);
    chk("t5_ovf", 32'(overflow), 32'(exp_ovf));
    drain(4, "t5");

    // csn rises together with the eighth sclk rise
    frame_begin(4);
    spi_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4, 8, 1'b0, 1'b0, 1'b1);
    repeat (S + 6) @(negedge clk);
    chk("t5b_ferr", 32'(frame_err), 32'(exp_ferr));
    drain(1, "t5b");
    miso_seen.delete();

    // random frames, random MISO byte and sclk rate
    repeat (6) begin
      n = $urandom_range(1, 3);
      h = $urandom_range(3, 6);
      miso_data = 8'($urandom_range(0, 255));
      frame_begin(h);
      for (int k = 0; k < n; k++) begin
        spi_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), h, 8, 1'b0, 1'b0, 1'b0);
      end
      frame_end(h, 1'b0);
      check_miso(miso_data, "rnd");
      drain(n, "rnd");
      chk("rnd_ferr", 32'(frame_err), 32'(exp_ferr));
    end

    // reset in the middle of a byte
    miso_data = 8'hFF;
    frame_begin(4);
    spi_byte(8'($urandom_range(0, 255)), 1'b1, 4, 8, 1'b0, 1'b0, 1'b0);
    spi_byte(8'($urandom_range(0, 255)), 1'b0, 4, 3, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_valid", 32'(rx_bus.rx_valid), 32'd1);
    chk("t6_pre_oe", 32'(spi_miso_oe), 32'd1);
    #7;
    rstn = 1'b0;
    #1;
    chk_reset("t6");
    exp_q.delete();
    miso_seen.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    spi_csn  = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    miso_data = 8'h5A;
    frame_begin(4);
    spi_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4, 8, 1'b0, 1'b0, 1'b0);
    frame_end(4, 1'b0);
    check_miso(8'h5A, "t6n");
    drain(1, "t6n");
    chk("t6n_ferr", 32'(frame_err), 32'(exp_ferr));
    chk("t6n_ovf", 32'(overflow), 32'(exp_ovf));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
